imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Instruction-memory slave serving the core's instruction fetch port: iproc_req/iaddr in, imem_rdy/ivalid/idata out.
- Backed by an on-chip word array with a programmable number of wait states.
- Holds one outstanding request at a time.
- Has a load port so the bench or boot logic can write the program image before or during run.

Parameters:
- NBITS, 32, data and address width.
- DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words).
- WAIT_STATES, 2, extra cycles per access, legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- iproc_req  input  1  fetch request from core
- iaddr  input  NBITS  fetch byte address
- imem_rdy  output  1  controller can accept a request this cycle
- ivalid  output  1  one-cycle pulse: idata holds the requested word
- idata  output  NBITS  fetched instruction
- load_en  input  1  write strobe for the program image
- load_addr  input  NBITS  byte address of the load
- load_data  input  NBITS  word to write

Behaviour:
- Reset (rst=0, asynchronous) drives the outputs to these values:
  - imem_rdy=1, ivalid=0, idata=32'h00000013 (NOP).
  - FSM=IDLE, wait counter=0.
  - Array contents are not reset.
- Handshake: a request is accepted at a rising edge where iproc_req=1 and imem_rdy=1. iaddr is captured at that edge.
- Word index is iaddr[DEPTH_LOG2+1:2]. iaddr[1:0] is ignored.
- Any nonzero bit in iaddr[NBITS-1:DEPTH_LOG2+2] makes the access out of range; it returns NOP and is otherwise timed normally.
- FSM states:
  - IDLE: imem_rdy=1. On accept with WAIT_STATES=0, go to RESP. On accept with WAIT_STATES>0, load counter=WAIT_STATES and go to WAIT.
  - WAIT: imem_rdy=0. Counter decrements each cycle. When counter reaches 1, go to RESP.
  - RESP: ivalid=1 and idata=array[idx], registered. imem_rdy=1, so a new request can be accepted at the same edge (back-to-back). With no new request, go to IDLE.
- Latency: ivalid is asserted exactly WAIT_STATES+1 cycles after the accepting edge. With WAIT_STATES=0, one word is returned every cycle.
- idata holds its last value until the next ivalid.
- iproc_req deasserted while in WAIT or RESP has no effect; the accepted request always completes.
- Load port:
  - load_en writes array[load_addr index] at the rising edge. Out-of-range load addresses are dropped.
  - Loads are allowed in any state.
  - A load to the word being read in the same RESP cycle returns the old data (read-before-write). The new data is visible from the next access.
- Reset asserted mid-access aborts it: no ivalid pulse is produced and the FSM returns to IDLE.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- With the macro defined:
  - A one-word prefetch buffer (pf_valid, pf_idx, pf_data) is filled at every RESP edge from array[idx+1]. The index wraps modulo 2^DEPTH_LOG2; an out-of-range idx leaves pf_valid=0.
  - A request accepted in IDLE or RESP whose index equals pf_idx while pf_valid=1 skips WAIT. ivalid follows one cycle later with pf_data.
  - A load to pf_idx clears pf_valid in the same edge.
  - Reset clears pf_valid.
- Without the macro: no buffer, and every access takes WAIT_STATES+1 cycles.

Decomposition:
- Package imem_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - State enum imem_state_t {IDLE, WAIT, RESP}.
  - Width of the wait-state counter (4 bits).
- Sub-module imem_array: a 2^DEPTH_LOG2 x NBITS register array with one synchronous write port (load port) and one registered read port. Under IMEM_PREFETCH_EN it has a second read port for the prefetch buffer.

Test Plan:
- Reset, then WAIT_STATES=2: load 0x00500093 at 0x0, request iaddr=0x0 at edge E → imem_rdy=0 for 2 cycles, ivalid=1 with idata=0x00500093 at E+3, imem_rdy=1.
- WAIT_STATES=0: iproc_req held high with iaddr 0x0, 0x4, 0x8 on consecutive cycles → three consecutive ivalid pulses with words 0, 1, 2 and no bubbles.
- Out-of-range iaddr=0x0001_0000 (DEPTH_LOG2=10) → ivalid after WAIT_STATES+1 cycles with idata=0x00000013; a load to the same address is dropped.
- During WAIT, drop iproc_req, then pulse rst low → no ivalid; after release imem_rdy=1, idata=NOP, and the next request completes normally.
- Load to word 3 in the same cycle as RESP for word 3 → old value returned; an immediate re-fetch of 0xC returns the new value.
- IMEM_PREFETCH_EN, WAIT_STATES=3: fetch 0x10 (latency 4), then 0x14 → ivalid 1 cycle after accept. A load to 0x18 between the fetches of 0x14 and 0x18 forces the fetch of 0x18 back to latency 4.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory controller.
//   NOP_INSTR    - word returned for out-of-range fetches and the reset value of idata
//   WCNT_W       - width of the wait-state counter
//   imem_state_t - controller FSM states
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          WCNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// imem_array: 2^DEPTH_LOG2 x NBITS word store for the instruction memory.
//   clk, rst             - clock, asynchronous active-low reset (read register only)
//   i_we/i_widx/i_wdata  - synchronous write port (program load)
//   i_re/i_ridx/i_roor   - registered read port; i_roor substitutes NOP_INSTR
//   o_rdata              - read register, holds until the next i_re
// With IMEM_PREFETCH_EN defined:
//   i_pf_en/i_pf_idx     - second read port, captures the prefetch word
//   i_rd_use_pf          - read port returns the prefetch word instead of the array
module imem_array
    import imem_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_widx,
    input  logic [NBITS-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_ridx,
    input  logic                  i_roor,
`ifdef IMEM_PREFETCH_EN
    input  logic                  i_rd_use_pf,
    input  logic                  i_pf_en,
    input  logic [DEPTH_LOG2-1:0] i_pf_idx,
`endif
    output logic [NBITS-1:0]      o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [NBITS-1:0] r_rdata;
    logic [NBITS-1:0] w_rd_word;

`ifdef IMEM_PREFETCH_EN
    logic [NBITS-1:0] r_pf_data;

    always_ff @(posedge clk) begin
        if (i_pf_en) r_pf_data <= r_mem[i_pf_idx];
    end

    assign w_rd_word = i_rd_use_pf ? r_pf_data : r_mem[i_ridx];
`else
    assign w_rd_word = r_mem[i_ridx];
`endif

    // Contents are never reset; the program image is loaded through the write port.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_widx] <= i_wdata;
    end

    // Reads sample the array before a same-edge write lands (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= NBITS'(NOP_INSTR);
        end else if (i_re) begin
            r_rdata <= i_roor ? NBITS'(NOP_INSTR) : w_rd_word;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory slave for the core fetch port, one request in flight.
//   clk, rst                 - clock, asynchronous active-low reset
//   iproc_req, iaddr         - fetch request and byte address (accepted when imem_rdy=1)
//   imem_rdy                 - controller can accept a request this cycle
//   ivalid, idata            - one-cycle response pulse and fetched word (idata holds)
//   load_en/addr/data        - program-image write port, usable in any state
// Latency from the accepting edge to ivalid is WAIT_STATES+1 cycles.
// Optional macro IMEM_PREFETCH_EN adds a one-word prefetch buffer holding the word
// after the last one served; a hit on it responds one cycle after acceptance.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int NBITS       = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iproc_req,
    input  logic [NBITS-1:0] iaddr,
    output logic             imem_rdy,
    output logic             ivalid,
    output logic [NBITS-1:0] idata,
    input  logic             load_en,
    input  logic [NBITS-1:0] load_addr,
    input  logic [NBITS-1:0] load_data
);

    localparam logic [WCNT_W-1:0] WS_CNT = WCNT_W'(WAIT_STATES);

    imem_state_t             r_state;
    logic [WCNT_W-1:0]       r_cnt;
    logic                    r_rdy;
    logic                    r_ivalid;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_oor;

    logic [DEPTH_LOG2-1:0]   w_req_idx;
    logic                    w_req_oor;
    logic [DEPTH_LOG2-1:0]   w_ld_idx;
    logic                    w_ld_oor;
    logic                    w_we;
    logic                    w_accept;
    logic                    w_resp;
    logic                    w_pf_hit;
    logic [NBITS-1:0]        w_rdata;

    // Any address bit above the array span makes the access out of range.
    assign w_req_idx = iaddr[DEPTH_LOG2+1:2];
    assign w_req_oor = |(iaddr >> (DEPTH_LOG2 + 2));
    assign w_ld_idx  = load_addr[DEPTH_LOG2+1:2];
    assign w_ld_oor  = |(load_addr >> (DEPTH_LOG2 + 2));
    assign w_we      = load_en && !w_ld_oor;

    assign w_accept  = iproc_req && r_rdy;
    assign w_resp    = (r_state == RESP);

`ifdef IMEM_PREFETCH_EN
    logic                  r_pf_valid;
    logic [DEPTH_LOG2-1:0] r_pf_idx;
    logic                  r_use_pf;
    logic [DEPTH_LOG2-1:0] w_pf_fill_idx;
    logic                  w_pf_fill;
    logic                  w_fill_clash;

    // Index wraps naturally at the array width.
    assign w_pf_fill_idx = r_idx + DEPTH_LOG2'(1);
    assign w_pf_fill     = w_resp && !r_oor;
    assign w_fill_clash  = w_we && (w_ld_idx == w_pf_fill_idx);

    // In RESP the buffer is being refilled at this very edge, so the hit is judged
    // against the word being captured; otherwise against the held buffer. A load to
    // the requested word at the accepting edge forces the slow path so the fetch
    // sees the new data.
    assign w_pf_hit = !w_req_oor && !(w_we && (w_ld_idx == w_req_idx)) &&
                      (w_resp ? (w_pf_fill && !w_fill_clash && (w_req_idx == w_pf_fill_idx))
                              : (r_pf_valid && (w_req_idx == r_pf_idx)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
        end else if (w_resp) begin
            r_pf_valid <= !r_oor && !w_fill_clash;
            r_pf_idx   <= w_pf_fill_idx;
        end else if (w_we && (w_ld_idx == r_pf_idx)) begin
            r_pf_valid <= 1'b0;
        end
    end
`else
    assign w_pf_hit = 1'b0;
`endif

    // ivalid is registered on the edge that leaves RESP, so it trails the state by one
    // cycle; this gives WAIT_STATES+1 cycles from the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rdy    <= 1'b1;
            r_ivalid <= 1'b0;
            r_idx    <= '0;
            r_oor    <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            r_use_pf <= 1'b0;
`endif
        end else begin
            r_ivalid <= w_resp;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_idx <= w_req_idx;
                        r_oor <= w_req_oor;
`ifdef IMEM_PREFETCH_EN
                        r_use_pf <= w_pf_hit;
`endif
                        if (WAIT_STATES == 0 || w_pf_hit) begin
                            r_state <= RESP;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_cnt   <= WS_CNT;
                            r_state <= WAIT;
                            r_rdy   <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - WCNT_W'(1);
                    if (r_cnt == WCNT_W'(1)) begin
                        r_state <= RESP;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    imem_array #(
        .NBITS      (NBITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_we),
        .i_widx      (w_ld_idx),
        .i_wdata     (load_data),
        .i_re        (w_resp),
        .i_ridx      (r_idx),
        .i_roor      (r_oor),
`ifdef IMEM_PREFETCH_EN
        .i_rd_use_pf (r_use_pf),
        .i_pf_en     (w_pf_fill),
        .i_pf_idx    (w_pf_fill_idx),
`endif
        .o_rdata     (w_rdata)
    );

    assign imem_rdy = r_rdy;
    assign ivalid   = r_ivalid;
    assign idata    = w_rdata;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: self-checking bench for imem_ctrl.
// Instance A uses the configured wait states (3 with IMEM_PREFETCH_EN, else 2);
// instance B uses zero wait states for back-to-back and read-before-write cases.
module tb_imem_ctrl;
    import imem_pkg::*;

`ifdef IMEM_PREFETCH_EN
    localparam int WS = 3;
    localparam bit PF = 1'b1;
`else
    localparam int WS = 2;
    localparam bit PF = 1'b0;
`endif
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_a, rdy_a, vld_a, ld_en_a;
    logic [31:0] addr_a, data_a, ld_addr_a, ld_data_a;
    logic        req_b, rdy_b, vld_b, ld_en_b;
    logic [31:0] addr_b, data_b, ld_addr_b, ld_data_b;

    imem_ctrl #(.NBITS(32), .DEPTH_LOG2(DL), .WAIT_STATES(WS)) u_dut_a (
        .clk(clk), .rst(rst), .iproc_req(req_a), .iaddr(addr_a), .imem_rdy(rdy_a),
        .ivalid(vld_a), .idata(data_a), .load_en(ld_en_a), .load_addr(ld_addr_a),
        .load_data(ld_data_a)
    );

    imem_ctrl #(.NBITS(32), .DEPTH_LOG2(DL), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst(rst), .iproc_req(req_b), .iaddr(addr_b), .imem_rdy(rdy_b),
        .ivalid(vld_b), .idata(data_b), .load_en(ld_en_b), .load_addr(ld_addr_b),
        .load_data(ld_data_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word contents and the prefetch rule "the buffer holds the word
    // after the last in-range word served, until a load to it or a reset".
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    bit          pfv_a = 1'b0;
    int          pfi_a = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit oor(input logic [31:0] a);
        return (a >> (DL + 2)) != 32'd0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[DL+1:2]);
    endfunction

    function automatic int exp_lat_a(input logic [31:0] a);
        if (PF && pfv_a && !oor(a) && widx(a) == pfi_a) return 1;
        return WS + 1;
    endfunction

    function automatic logic [31:0] exp_dat_a(input logic [31:0] a);
        return oor(a) ? NOP : mem_a[widx(a)];
    endfunction

    function automatic void served_a(input logic [31:0] a);
        if (oor(a)) begin
            pfv_a = 1'b0;
        end else begin
            pfv_a = 1'b1;
            pfi_a = (widx(a) + 1) % DEPTH;
        end
    endfunction

    task automatic load_a(input logic [31:0] a, input logic [31:0] d);
        ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
        tick();
        ld_en_a = 1'b0; ld_addr_a = $urandom;
        if (!oor(a)) begin
            mem_a[widx(a)] = d;
            if (widx(a) == pfi_a) pfv_a = 1'b0;
        end
    endtask

    // Issue one request on A from an idle controller; report cycles to ivalid
    // (0 on timeout), the returned word and how many sampled cycles had imem_rdy=0.
    task automatic fetch_a(input logic [31:0] a, output int lat, output logic [31:0] got,
                           output int low);
        req_a = 1'b1; addr_a = a;
        tick();
        req_a = 1'b0; addr_a = $urandom;
        lat = 0; got = 32'hDEADBEEF;
        low = rdy_a ? 0 : 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (vld_a) begin
                lat = k; got = data_a;
                break;
            end
            if (!rdy_a) low++;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
        tick();
        pfv_a = 1'b0;
    endtask

    task automatic test_reset();
        req_a = 0; addr_a = 0; ld_en_a = 0; ld_addr_a = 0; ld_data_a = 0;
        req_b = 0; addr_b = 0; ld_en_b = 0; ld_addr_b = 0; ld_data_b = 0;
        #1 rst = 1'b0;
        repeat (3) tick();
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got=%0b exp=1", rdy_a); end
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_vld got=%0b exp=0", vld_a); end
        n_tests++; if (data_a !== NOP) begin n_fail++; $display("FAIL reset_in_data got=%h exp=%h", data_a, NOP); end
        #3 rst = 1'b1;
        tick();
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_a got=%0b exp=1", rdy_a); end
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld_a got=%0b exp=0", vld_a); end
        n_tests++; if (data_a !== NOP) begin n_fail++; $display("FAIL reset_data_a got=%h exp=%h", data_a, NOP); end
        n_tests++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_b got=%0b exp=1", rdy_b); end
        n_tests++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL reset_vld_b got=%0b exp=0", vld_b); end
        n_tests++; if (data_b !== NOP) begin n_fail++; $display("FAIL reset_data_b got=%h exp=%h", data_b, NOP); end
    endtask

    task automatic init_mem();
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] da, db, ad;
            da = $urandom; db = $urandom;
            ad = (32'(i) << 2) | ($urandom & 32'h3);
            ld_en_a = 1'b1; ld_addr_a = ad; ld_data_a = da;
            ld_en_b = 1'b1; ld_addr_b = ad; ld_data_b = db;
            tick();
            mem_a[i] = da; mem_b[i] = db;
        end
        ld_en_a = 1'b0; ld_en_b = 1'b0;
    endtask

    task automatic test_wait_latency();
        int lat, low, el;
        logic [31:0] got, ed;
        load_a(32'h0, 32'h00500093);
        el = exp_lat_a(32'h0); ed = exp_dat_a(32'h0);
        fetch_a(32'h0, lat, got, low);
        served_a(32'h0);
        n_tests++; if (lat != el) begin n_fail++; $display("FAIL wait_lat got=%0d exp=%0d", lat, el); end
        n_tests++; if (got !== ed) begin n_fail++; $display("FAIL wait_data got=%h exp=%h", got, ed); end
        n_tests++; if (low != el - 1) begin n_fail++; $display("FAIL wait_rdy_low got=%0d exp=%0d", low, el - 1); end
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL wait_rdy_at_vld got=%0b exp=1", rdy_a); end
        tick();
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL wait_pulse got=%0b exp=0", vld_a); end
        n_tests++; if (data_a !== ed) begin n_fail++; $display("FAIL wait_hold got=%h exp=%h", data_a, ed); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [8];
        adrs[0] = 32'h0; adrs[1] = 32'h4; adrs[2] = 32'h8;
        for (int i = 3; i < 8; i++) adrs[i] = (($urandom % DEPTH) << 2) | ($urandom & 32'h3);
        req_b = 1'b1; addr_b = adrs[0];
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) addr_b = adrs[i];
            else req_b = 1'b0;
            tick();
            n_tests++; if (vld_b !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d] got=%0b exp=1", i - 1, vld_b); end
            n_tests++; if (data_b !== mem_b[widx(adrs[i-1])]) begin
                n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i - 1, data_b, mem_b[widx(adrs[i-1])]);
            end
            n_tests++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy[%0d] got=%0b exp=1", i - 1, rdy_b); end
        end
        tick();
        n_tests++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL b2b_end_vld got=%0b exp=0", vld_b); end
    endtask

    task automatic test_rbw();
        logic [31:0] old, nw;
        old = mem_b[3];
        nw  = old ^ (32'h1 | $urandom);
        req_b = 1'b1; addr_b = 32'hC;
        tick();
        ld_en_b = 1'b1; ld_addr_b = 32'hC; ld_data_b = nw;
        tick();
        mem_b[3] = nw;
        n_tests++; if (vld_b !== 1'b1) begin n_fail++; $display("FAIL rbw_vld1 got=%0b exp=1", vld_b); end
        n_tests++; if (data_b !== old) begin n_fail++; $display("FAIL rbw_old got=%h exp=%h", data_b, old); end
        ld_en_b = 1'b0; req_b = 1'b0;
        tick();
        n_tests++; if (vld_b !== 1'b1) begin n_fail++; $display("FAIL rbw_vld2 got=%0b exp=1", vld_b); end
        n_tests++; if (data_b !== nw) begin n_fail++; $display("FAIL rbw_new got=%h exp=%h", data_b, nw); end
        tick();
    endtask

    task automatic test_out_of_range();
        int lat, low, el;
        logic [31:0] got, ed;
        el = exp_lat_a(32'h0001_0000);
        fetch_a(32'h0001_0000, lat, got, low);
        served_a(32'h0001_0000);
        n_tests++; if (lat != el) begin n_fail++; $display("FAIL oor_lat got=%0d exp=%0d", lat, el); end
        n_tests++; if (got !== NOP) begin n_fail++; $display("FAIL oor_data got=%h exp=%h", got, NOP); end
        load_a(32'h0001_0000, 32'hCAFEF00D);
        el = exp_lat_a(32'h0); ed = exp_dat_a(32'h0);
        fetch_a(32'h0, lat, got, low);
        served_a(32'h0);
        n_tests++; if (lat != el) begin n_fail++; $display("FAIL oor_load_lat got=%0d exp=%0d", lat, el); end
        n_tests++; if (got !== ed) begin n_fail++; $display("FAIL oor_load_dropped got=%h exp=%h", got, ed); end
    endtask

    task automatic test_reset_abort();
        int lat, low, el;
        logic [31:0] got, ed;
        bit seen;
        req_a = 1'b1; addr_a = 32'h4;
        tick();
        req_a = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL abort_in_vld got=%0b exp=0", vld_a); end
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL abort_in_rdy got=%0b exp=1", rdy_a); end
        n_tests++; if (data_a !== NOP) begin n_fail++; $display("FAIL abort_in_data got=%h exp=%h", data_a, NOP); end
        seen = 1'b0;
        tick(); seen |= vld_a;
        tick(); seen |= vld_a;
        #3 rst = 1'b1;
        pfv_a = 1'b0;
        for (int k = 0; k < WS + 3; k++) begin
            tick(); seen |= vld_a;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_vld got=%0b exp=0", seen); end
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL abort_rdy got=%0b exp=1", rdy_a); end
        n_tests++; if (data_a !== NOP) begin n_fail++; $display("FAIL abort_data got=%h exp=%h", data_a, NOP); end
        el = exp_lat_a(32'h4); ed = exp_dat_a(32'h4);
        fetch_a(32'h4, lat, got, low);
        served_a(32'h4);
        n_tests++; if (lat != el) begin n_fail++; $display("FAIL abort_next_lat got=%0d exp=%0d", lat, el); end
        n_tests++; if (got !== ed) begin n_fail++; $display("FAIL abort_next_data got=%h exp=%h", got, ed); end
    endtask

    task automatic test_random();
        int lat, low, el, r;
        logic [31:0] got, ed, a, prev;
        prev = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom % 4 == 0) begin
                if ($urandom % 2 == 0) load_a(32'(pfi_a) << 2, $urandom);
                else load_a(($urandom % DEPTH) << 2, $urandom);
            end
            r = int'($urandom % 8);
            if (r == 0) a = (32'h1 << (12 + $urandom % 20)) | ($urandom & 32'hFFF);
            else if (r < 5) a = (32'((widx(prev) + 1) % DEPTH) << 2) | ($urandom & 32'h3);
            else a = (($urandom % DEPTH) << 2) | ($urandom & 32'h3);
            el = exp_lat_a(a); ed = exp_dat_a(a);
            fetch_a(a, lat, got, low);
            served_a(a);
            n_tests++; if (lat != el) begin n_fail++; $display("FAIL rnd_lat[%0d] addr=%h got=%0d exp=%0d", i, a, lat, el); end
            n_tests++; if (got !== ed) begin n_fail++; $display("FAIL rnd_data[%0d] addr=%h got=%h exp=%h", i, a, got, ed); end
            n_tests++; if (low != el - 1) begin n_fail++; $display("FAIL rnd_rdy_low[%0d] got=%0d exp=%0d", i, low, el - 1); end
            prev = a;
        end
    endtask

`ifdef IMEM_PREFETCH_EN
    task automatic test_prefetch();
        int lat, low;
        logic [31:0] got;
        reset_pulse();
        fetch_a(32'h10, lat, got, low); served_a(32'h10);
        n_tests++; if (lat != WS + 1) begin n_fail++; $display("FAIL pf_cold_lat got=%0d exp=%0d", lat, WS + 1); end
        n_tests++; if (got !== mem_a[4]) begin n_fail++; $display("FAIL pf_cold_data got=%h exp=%h", got, mem_a[4]); end
        fetch_a(32'h14, lat, got, low); served_a(32'h14);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL pf_hit_lat got=%0d exp=1", lat); end
        n_tests++; if (got !== mem_a[5]) begin n_fail++; $display("FAIL pf_hit_data got=%h exp=%h", got, mem_a[5]); end
        load_a(32'h18, $urandom);
        fetch_a(32'h18, lat, got, low); served_a(32'h18);
        n_tests++; if (lat != WS + 1) begin n_fail++; $display("FAIL pf_inval_lat got=%0d exp=%0d", lat, WS + 1); end
        n_tests++; if (got !== mem_a[6]) begin n_fail++; $display("FAIL pf_inval_data got=%h exp=%h", got, mem_a[6]); end
        fetch_a(32'h1C, lat, got, low); served_a(32'h1C);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL pf_seq_lat got=%0d exp=1", lat); end
        n_tests++; if (got !== mem_a[7]) begin n_fail++; $display("FAIL pf_seq_data got=%h exp=%h", got, mem_a[7]); end
        fetch_a(32'hFFC, lat, got, low); served_a(32'hFFC);
        n_tests++; if (lat != WS + 1) begin n_fail++; $display("FAIL pf_top_lat got=%0d exp=%0d", lat, WS + 1); end
        fetch_a(32'h0, lat, got, low); served_a(32'h0);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL pf_wrap_lat got=%0d exp=1", lat); end
        n_tests++; if (got !== mem_a[0]) begin n_fail++; $display("FAIL pf_wrap_data got=%h exp=%h", got, mem_a[0]); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem();
        test_wait_latency();
        test_back_to_back();
        test_rbw();
        test_out_of_range();
        test_reset_abort();
        test_random();
`ifdef IMEM_PREFETCH_EN
        test_prefetch();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
